// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin grant between requester 0 and 1,
// one APB transfer at a time, with an optional ACCESS-phase timeout.
module apb_req_arbiter #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WR0,
  input  logic              WR1,
  input  logic [AWIDTH-1:0] ADDR0,
  input  logic [AWIDTH-1:0] ADDR1,
  input  logic [DWIDTH-1:0] WDATA0,
  input  logic [DWIDTH-1:0] WDATA1,
  output logic              ACK0,
  output logic              ACK1,
  output logic              ERR0,
  output logic              ERR1,
  output logic [DWIDTH-1:0] RDATA0,
  output logic [DWIDTH-1:0] RDATA1,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY
);

  // state  | meaning
  // IDLE   | no transfer; arbitrate pending requests each edge
  // SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
  // ACCESS | PSEL=PENABLE=1 until PREADY or timeout
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic [DWIDTH-1:0] rdata0_q, rdata0_d;
  logic [DWIDTH-1:0] rdata1_q, rdata1_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_q, gnt_d;

  logic req0_v;
  logic req1_v;
  logic gnt_next;
  logic timeout_hit;

  // A requester is masked during its own ACK cycle so it can drop REQ there.
  assign req0_v      = REQ0 & ~ack0_q;
  assign req1_v      = REQ1 & ~ack1_q;
  assign gnt_next    = (req0_v & req1_v) ? ~last_gnt_q : req1_v;
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    wait_cnt_d = wait_cnt_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;

    case (state_q)
      IDLE: begin
        if (req0_v || req1_v) begin
          gnt_d      = gnt_next;
          pwrite_d   = gnt_next ? WR1 : WR0;
          paddr_d    = gnt_next ? ADDR1 : ADDR0;
          pwdata_d   = gnt_next ? WDATA1 : WDATA0;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY || timeout_hit) begin
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          last_gnt_d = gnt_q;
          state_d    = IDLE;
          if (gnt_q) begin
            ack1_d = 1'b1;
            err1_d = ~PREADY;
            if (PREADY && !pwrite_q) rdata1_d = PRDATA;
          end else begin
            ack0_d = 1'b1;
            err0_d = ~PREADY;
            if (PREADY && !pwrite_q) rdata0_d = PRDATA;
          end
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= IDLE;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      wait_cnt_q <= '0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      wait_cnt_q <= wait_cnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign ACK0    = ack0_q;
  assign ACK1    = ack1_q;
  assign ERR0    = err0_q;
  assign ERR1    = err1_q;
  assign RDATA0  = rdata0_q;
  assign RDATA1  = rdata1_q;

endmodule
